// File: rtl/bp_pkg.sv
// bp_pkg: shared sizes, counter encodings and entry record for the branch predictor
package bp_pkg;
  localparam int BP_ENTRIES = 8;
  localparam int BP_IDX_W = 3;
  localparam int BP_TAG_W = 12;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;
  typedef struct packed {
    logic valid;
    logic [BP_TAG_W-1:0] tag;
    logic [1:0] ctr;
    logic [15:0] target;
  } bp_entry_t;
endpackage

// File: rtl/sat_counter_2b.sv
// sat_counter_2b: 2-bit saturating direction counter, load has priority over inc/dec
// Ports: clk, rst_n (async, active-low, resets to weak-NT), inc, dec, load, load_val[1:0], cnt[1:0]
module sat_counter_2b
  import bp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] cnt
);
  logic [1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = load ? load_val :
            (inc && cnt_q != CTR_ST) ? cnt_q + 2'd1 :
            (dec && cnt_q != CTR_SNT) ? cnt_q - 2'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= CTR_WNT;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 8-entry direct-mapped BHT+BTB with combinational prediction
// Ports: clk, rst_n (async, active-low); PC_curr -> predicted_taken, predicted_target;
//        IF_ID_PC_curr, wen_BHT, wen_BTB, actual_taken, actual_target update the indexed entry
module branch_predictor
  import bp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] PC_curr,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic        wen_BHT,
  input  logic        wen_BTB,
  input  logic        actual_taken,
  input  logic [15:0] actual_target
);
  logic                valid_q [BP_ENTRIES];
  logic [BP_TAG_W-1:0] tag_q [BP_ENTRIES];
  logic [15:0]         target_q [BP_ENTRIES];
  logic [1:0]          ctr [BP_ENTRIES];
  bp_entry_t           ent [BP_ENTRIES];
  logic [BP_IDX_W-1:0] ridx, uidx;
  logic [BP_TAG_W-1:0] utag;
  logic                rhit, uhit, alloc, tgt_we;
  logic [1:0]          alloc_ctr;
  logic                unused;
  // Bit 0 of both PCs is never part of index or tag
  assign unused = ^{PC_curr[0], IF_ID_PC_curr[0]};
  assign ridx = PC_curr[3:1];
  assign uidx = IF_ID_PC_curr[3:1];
  assign utag = IF_ID_PC_curr[15:4];
  always_comb begin
    rhit = ent[ridx].valid && ent[ridx].tag == PC_curr[15:4];
    uhit = ent[uidx].valid && ent[uidx].tag == utag;
    alloc = (wen_BHT || wen_BTB) && !uhit;
    tgt_we = alloc || (uhit && wen_BTB);
    // A BTB-only allocation has no direction information, so it starts weak-NT
    alloc_ctr = (wen_BHT && actual_taken) ? CTR_WT : CTR_WNT;
    predicted_taken = rhit && ent[ridx].ctr[1];
    predicted_target = rhit ? ent[ridx].target : 16'h0000;
  end
  for (genvar i = 0; i < BP_ENTRIES; i++) begin : g_ent
    logic sel;
    assign sel = uidx == BP_IDX_W'(i);
    sat_counter_2b u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (sel && uhit && wen_BHT && actual_taken),
      .dec      (sel && uhit && wen_BHT && !actual_taken),
      .load     (sel && alloc),
      .load_val (alloc_ctr),
      .cnt      (ctr[i])
    );
    assign ent[i] = '{valid: valid_q[i], tag: tag_q[i], ctr: ctr[i], target: target_q[i]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < BP_ENTRIES; k++) begin
        valid_q[k] <= 1'b0;
        tag_q[k] <= '0;
        target_q[k] <= '0;
      end
    end else begin
      if (alloc) begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx] <= utag;
      end
      if (tgt_we) target_q[uidx] <= actual_target;
    end
endmodule
